gray_ro_sched: RTL and testbench
================================

# gray_ro_sched

Round-robin readout scheduler that shares one serial output line among `N_CH` gray-code readout channels. Each channel raises a request when its gray word is ready; the scheduler grants one channel, acknowledges it, converts its word to binary, and serializes a framed packet (start, channel ID, data, parity, stop). It sits between the per-channel `gray_ro` counters and the chip-level serial pad.

## Interface
Parameters:
- `N_CH`, 8: number of readout channels (power of two, ≥2)
- `W`, 8: gray word width per channel
- `CH_W`, `$clog2(N_CH)`: channel ID width (derived, not overridden)

Ports:
- `clk_ext`  in  1  system clock (same domain as `gray_ro`)
- `rst_ext`  in  1  asynchronous, active-low reset
- `en`  in  1  scheduler enable; sampled only in IDLE
- `ch_req`  in  N_CH  per-channel level request; held until acked
- `ch_data`  in  N_CH*W  gray words, channel k at bits [k*W +: W]
- `ch_ack`  out  N_CH  one-hot, one-cycle acknowledge of the granted channel
- `ser_out`  out  1  serial data, idles low
- `ser_frame`  out  1  high for every bit of a frame
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, START, ID, DATA, PAR, STOP.
- IDLE: if `en`=1 and `ch_req`≠0, select the first requesting channel at or after `ptr` (circular). On that edge: pulse `ch_ack[g]` for one cycle, latch `bin = gray2bin(ch_data[g])` and `id = g`, set `ptr = (g+1) mod N_CH`, go to START.
- START: `ser_out`=1 for one cycle.
- ID: `CH_W` cycles, `id` MSB first.
- DATA: `W` cycles, `bin` MSB first.
- PAR: one cycle, even parity: XOR of all ID and DATA bits.
- STOP: `ser_out`=0 for one cycle, then IDLE.
- Gray→binary: `b[W-1]=g[W-1]`, `b[i]=b[i+1]^g[i]`. The data is captured at grant; later changes of `ch_data` do not affect the frame.
- `en` deasserted mid-frame: the current frame completes, then the block stays in IDLE.
- A channel that drops `ch_req` before grant is skipped without error.
- Only one bit counter runs; it is reloaded on entry to ID and DATA.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, `ptr`=0, `ch_ack`=0, `ser_out`=0, `ser_frame`=0, `busy`=0, shift registers 0.
- Frame length F = 1+CH_W+W+1+1 cycles (14 at defaults). `ser_frame`=1 for exactly F cycles, starting the cycle after the grant edge.
- Minimum one IDLE cycle between frames, so the maximum throughput is one word per F+1 cycles (15 at defaults).
- `ch_ack` is high for the single cycle following the grant edge. That cycle coincides with START.
- A request arriving during a frame is serviced at the next IDLE arbitration in round-robin order. There are no lost or duplicated acks.
- Reset asserted mid-frame aborts the frame at once: `ser_out` and `ser_frame` go to 0, and no ack is issued after reset.
- All outputs are registered (no combinational path from inputs to outputs).

## Structure
- Shared package `gray_ro_pkg`: state enum, `N_CH` and `W` defaults, and frame-length constant `F`.
- Sub-module `gray2bin` (parameter `W`): purely combinational converter, reusable by other readout blocks.
- Arbiter (rotate, find-first, rotate back) lives inline in `gray_ro_sched`.

## Test plan
- Single request: reset, `en`=1, `ch_req`=8'b0000_0100, ch2 gray=8'b1100_0000.
  - `ch_ack[2]` pulses once.
  - Frame is 1,010,10000000,0,0 (parity = 0, since ID has one 1 and data has one 1).
  - `ser_frame` is high for 14 cycles.
- Round-robin fairness: all 8 requests held high.
  - Grant order is 0,1,…,7,0.
  - Frames are spaced every 15 cycles.
  - Each ack is exactly one cycle.
- Pointer wrap: after a ch6 grant, raise only ch1 and ch7 → ch7 is granted first, then ch1.
- Gray conversion: ch0 gray=8'b1111_1111 → DATA bits 10101010, parity=0. Gray=8'b0000_0001 → DATA 00000001, parity=1.
- Enable and late changes:
  - Drop `en` in the middle of DATA → the frame completes, no further grants occur, and `busy` falls after STOP.
  - Changing `ch_data` mid-frame has no effect on `ser_out`.
- Reset mid-frame: assert `rst_ext`=0 during ID.
  - All outputs are 0 in the same cycle.
  - After release with ch3 requesting, the first grant is ch3, because `ptr` restarts at 0.

Source files
------------

// File: rtl/gray_ro_pkg.sv
// Shared definitions for the gray-code readout blocks: scheduler states,
// default geometry and the resulting serial frame length.
package gray_ro_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ID,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  localparam int N_CH_DEF = 8;
  localparam int W_DEF    = 8;

  // start + channel id + data + parity + stop
  localparam int F = 1 + $clog2(N_CH_DEF) + W_DEF + 1 + 1;

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all
// gray bits at or above its position.
module gray2bin #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[W-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_ro_sched.sv
// Round-robin readout scheduler: grants one requesting gray_ro channel,
// converts its word to binary and shifts out a framed serial packet.
module gray_ro_sched
  import gray_ro_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF
) (
  input  logic              clk_ext,
  input  logic              rst_ext,
  input  logic              en,
  input  logic [N_CH-1:0]   ch_req,
  input  logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_ack,
  output logic              ser_out,
  output logic              ser_frame,
  output logic              busy
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int SW    = (W > CH_W) ? W : CH_W;
  localparam int CNT_W = $clog2(SW + 1);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [SW-1:0]     r_sh, w_sh_next;
  logic [CH_W-1:0]   r_ptr, r_id;
  logic [W-1:0]      r_bin;
  logic [N_CH-1:0]   r_ack;
  logic              r_ser_out, r_ser_frame, r_busy;

  logic [2*N_CH-1:0] w_dbl;
  logic [N_CH-1:0]   w_rot;
  logic [CH_W-1:0]   w_off, w_gnt;
  logic              w_grant;
  logic [W-1:0]      w_gray_sel, w_bin;
  logic [SW-1:0]     w_id_al, w_bin_al;
  logic [N_CH-1:0]   w_ack_next;
  logic              w_ser_out_next, w_frame_next;

  // Arbiter: rotate requests so ptr sits at bit 0, pick the lowest set bit,
  // then add ptr back (wraps naturally because N_CH is a power of two).
  assign w_dbl = {ch_req, ch_req} >> r_ptr;
  assign w_rot = w_dbl[N_CH-1:0];

  always_comb begin
    w_off = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = CH_W'(k);
    end
  end

  assign w_gnt      = r_ptr + w_off;
  assign w_grant    = (r_state == ST_IDLE) && en && (|ch_req);
  assign w_gray_sel = ch_data[w_gnt*W +: W];

  gray2bin #(.W(W)) u_gray2bin (
    .i_gray (w_gray_sel),
    .o_bin  (w_bin)
  );

  assign w_id_al  = SW'(r_id)  << (SW - CH_W);
  assign w_bin_al = SW'(r_bin) << (SW - W);

  always_ff @(posedge clk_ext or negedge rst_ext) begin
    if (!rst_ext) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_sh    <= w_sh_next;
    end
  end

  // The single bit counter is reloaded on entry to ID and to DATA.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_sh_next    = r_sh;
    case (r_state)
      ST_IDLE:  if (w_grant) w_state_next = ST_START;
      ST_START: begin
        w_state_next = ST_ID;
        w_cnt_next   = CNT_W'(CH_W - 1);
        w_sh_next    = w_id_al;
      end
      ST_ID: begin
        if (r_cnt == '0) begin
          w_state_next = ST_DATA;
          w_cnt_next   = CNT_W'(W - 1);
          w_sh_next    = w_bin_al;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
          w_sh_next  = r_sh << 1;
        end
      end
      ST_DATA: begin
        if (r_cnt == '0) begin
          w_state_next = ST_PAR;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
          w_sh_next  = r_sh << 1;
        end
      end
      ST_PAR:  w_state_next = ST_STOP;
      ST_STOP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they can be registered.
  always_comb begin
    w_ser_out_next = 1'b0;
    case (w_state_next)
      ST_START:       w_ser_out_next = 1'b1;
      ST_ID, ST_DATA: w_ser_out_next = w_sh_next[SW-1];
      ST_PAR:         w_ser_out_next = ^{r_id, r_bin};
      default:        w_ser_out_next = 1'b0;
    endcase
    w_frame_next = (w_state_next != ST_IDLE);
    w_ack_next   = w_grant ? (N_CH'(1) << w_gnt) : '0;
  end

  always_ff @(posedge clk_ext or negedge rst_ext) begin
    if (!rst_ext) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_bin       <= '0;
      r_ack       <= '0;
      r_ser_out   <= 1'b0;
      r_ser_frame <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_grant) begin
        r_ptr <= w_gnt + 1'b1;
        r_id  <= w_gnt;
        r_bin <= w_bin;
      end
      r_ack       <= w_ack_next;
      r_ser_out   <= w_ser_out_next;
      r_ser_frame <= w_frame_next;
      r_busy      <= w_frame_next;
    end
  end

  assign ch_ack    = r_ack;
  assign ser_out   = r_ser_out;
  assign ser_frame = r_ser_frame;
  assign busy      = r_busy;

endmodule

// File: tb/tb_gray_ro_sched.sv
// Bench for gray_ro_sched: directed scenarios plus random traffic, checked
// every cycle against a frame-queue model of the scheduler.
module tb_gray_ro_sched;
  import gray_ro_pkg::*;

  localparam int N  = N_CH_DEF;
  localparam int W  = W_DEF;
  localparam int CW = $clog2(N_CH_DEF);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   ack;
  logic           so, sf, bsy;

  gray_ro_sched #(.N_CH(N), .W(W)) dut (
    .clk_ext   (clk),
    .rst_ext   (rst_n),
    .en        (en),
    .ch_req    (req),
    .ch_data   (data),
    .ch_ack    (ack),
    .ser_out   (so),
    .ser_frame (sf),
    .busy      (bsy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: a granted frame becomes a queue of expected serial bits.
  int           m_ptr = 0;
  bit           m_frame = 1'b0;
  bit           m_out = 1'b0;
  bit           m_q[$];
  logic [N-1:0] m_ack = '0;

  bit           auto_drop = 1'b1;
  logic [N-1:0] ack_log[$];
  logic [31:0]  cap = '0;
  int           cap_n = 0;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ptr   = 0;
    m_frame = 1'b0;
    m_out   = 1'b0;
    m_ack   = '0;
  endtask

  task automatic model_edge();
    int           g;
    bit           found;
    bit           par;
    logic [W-1:0] b;
    logic [31:0]  gv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_ack = '0;
    if (!m_frame && en && req != '0) begin
      found = 1'b0;
      g = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!found && req[c]) begin
          g = c;
          found = 1'b1;
        end
      end
      gv  = 32'(g);
      b   = g2b(data[g*W +: W]);
      par = 1'b0;
      m_q.push_back(1'b1);
      for (int i = CW - 1; i >= 0; i--) begin
        m_q.push_back(gv[i]);
        par ^= gv[i];
      end
      for (int i = W - 1; i >= 0; i--) begin
        m_q.push_back(b[i]);
        par ^= b[i];
      end
      m_q.push_back(par);
      m_q.push_back(1'b0);
      m_ack[g] = 1'b1;
      m_ptr = (g + 1) % N;
    end
    if (m_q.size() > 0) begin
      m_out   = m_q.pop_front();
      m_frame = 1'b1;
    end else begin
      m_out   = 1'b0;
      m_frame = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("ser_out",   32'(so),  32'(m_out));
    check_eq("ser_frame", 32'(sf),  32'(m_frame));
    check_eq("busy",      32'(bsy), 32'(m_frame));
    check_eq("ch_ack",    32'(ack), 32'(m_ack));
    if (ack != '0) ack_log.push_back(ack);
    if (sf) begin
      cap = {cap[30:0], so};
      cap_n++;
    end
    if (auto_drop) req = req & ~m_ack;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ack"},   32'(ack), 32'd0);
    check_eq({tag, "_out"},   32'(so),  32'd0);
    check_eq({tag, "_frame"}, 32'(sf),  32'd0);
    check_eq({tag, "_busy"},  32'(bsy), 32'd0);
  endtask

  // Called just after a negedge: assert reset between edges, check outputs
  // clear at once, hold reset over one edge, release at the next negedge.
  task automatic async_reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1 check_all_zero(tag);
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_log(input string tag, input int idx, input logic [N-1:0] exp);
    if (idx < ack_log.size()) check_eq(tag, 32'(ack_log[idx]), 32'(exp));
    else check_eq(tag, 32'hFFFF_FFFF, 32'(exp));
  endtask

  task automatic check_frame(input string tag, input logic [13:0] exp);
    check_eq({tag, "_len"},  32'(cap_n), 32'(F));
    check_eq({tag, "_bits"}, 32'(cap[13:0]), 32'(exp));
  endtask

  initial begin
    for (int k = 0; k < N; k++) data[k*W +: W] = W'($urandom);
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // All channels held: grants 0..7,0 every F+1 cycles.
    en = 1'b1;
    auto_drop = 1'b0;
    req = '1;
    ack_log.delete();
    run(130);
    req = '0;
    run(20);
    check_eq("rr_count", 32'(ack_log.size()), 32'd9);
    for (int i = 0; i < 9; i++) check_log("rr_order", i, N'(1) << (i % N));
    auto_drop = 1'b1;

    // Single request on ch2.
    data[2*W +: W] = 8'b1100_0000;
    req = 8'b0000_0100;
    cap = '0; cap_n = 0;
    ack_log.delete();
    run(20);
    check_frame("single", 14'b1_010_10000000_0_0);
    check_eq("single_acks", 32'(ack_log.size()), 32'd1);
    check_log("single_ack", 0, 8'h04);

    // Pointer wrap: ch6 first, then ch1 and ch7 together.
    req = 8'h40;
    ack_log.delete();
    run(16);
    req = req | 8'h82;
    run(32);
    check_log("wrap0", 0, 8'h40);
    check_log("wrap1", 1, 8'h80);
    check_log("wrap2", 2, 8'h02);

    // Gray conversion on ch0.
    data[0 +: W] = 8'b1111_1111;
    req = 8'h01;
    cap = '0; cap_n = 0;
    run(17);
    check_frame("gray_ff", 14'b1_000_10101010_0_0);
    data[0 +: W] = 8'b0000_0001;
    req = 8'h01;
    cap = '0; cap_n = 0;
    run(17);
    check_frame("gray_01", 14'b1_000_00000001_1_0);

    // Drop en in DATA while data wiggles; others keep requesting.
    req = 8'h0F;
    ack_log.delete();
    step();
    repeat (6) begin
      for (int k = 0; k < N; k++) data[k*W +: W] = W'($urandom);
      step();
    end
    en = 1'b0;
    repeat (30) begin
      for (int k = 0; k < N; k++) data[k*W +: W] = W'($urandom);
      step();
    end
    check_eq("en_drop_acks", 32'(ack_log.size()), 32'd1);

    // Reset during ID; afterwards ch3 must win because ptr restarts at 0.
    en = 1'b1;
    step();
    step();
    async_reset_pulse("rst_mid");
    req = 8'h08;
    ack_log.delete();
    run(16);
    check_log("rst_first", 0, 8'h08);

    // Random traffic.
    en = 1'b1;
    req = '0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) req[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 29) == 0) req[$urandom_range(0, N - 1)] = 1'b0;
      if ($urandom_range(0, 1) == 1) data[$urandom_range(0, N - 1)*W +: W] = W'($urandom);
      step();
      if ($urandom_range(0, 299) == 0) async_reset_pulse("rst_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
